// File: rtl/des128_byte_loader_pkg.sv
// Shared definitions for the 128-bit DES byte loader: block geometry,
// controller state encoding and a saturating byte-count step.
package des128_byte_loader_pkg;

    localparam int NBYTES  = 16;
    localparam int BYTE_W  = 8;
    localparam int BLOCK_W = NBYTES * BYTE_W;
    localparam int CNT_W   = 5;

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_START   = 3'd1,
        ST_RUN     = 3'd2,
        ST_WAITCAP = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    // Byte counter holds at NBYTES rather than wrapping.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(NBYTES)) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/des128_byte_shifter.sv
// 128-bit register with parallel load and byte-wide left shift (new byte enters
// at the LSB end), plus a count of bytes shifted since the last load/clear.
module des128_byte_shifter
    import des128_byte_loader_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               shift,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               clear,
    output logic [BLOCK_W-1:0] data,
    output logic [CNT_W-1:0]   cnt
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= load_data;
            cnt  <= '0;
        end else begin
            if (shift) begin
                data <= {data[BLOCK_W-BYTE_W-1:0], byte_in};
            end
            // A clear wins over a coincident shift so the next block starts at zero.
            if (clear) begin
                cnt <= '0;
            end else if (shift) begin
                cnt <= cnt_step(cnt);
            end
        end
    end

endmodule

// File: rtl/des128_byte_loader.sv
// Byte-stream shell around the 128-bit DES core: assembles a plaintext block,
// restarts the core, waits for Done (with timeout), captures and drains the ciphertext.
module des128_byte_loader
    import des128_byte_loader_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CAP_DLY = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [BLOCK_W-1:0] Key_in,
    input  logic               Key_load,
    input  logic [BYTE_W-1:0]  In_data,
    input  logic               In_valid,
    output logic               In_ready,
    output logic [BLOCK_W-1:0] Plaintext_o,
    output logic [BLOCK_W-1:0] Key_o,
    output logic               Core_rst,
    input  logic               Core_done,
    input  logic [BLOCK_W-1:0] Cipher_i,
    output logic [BYTE_W-1:0]  Out_data,
    output logic               Out_valid,
    input  logic               Out_ready,
    output logic               Busy,
    output logic               Timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t               state_q;
    state_t               state_d;
    logic [TMR_W-1:0]     timer_q;
    logic                 armed_q;
    logic                 timeout_q;
    logic [BLOCK_W-1:0]   key_q;

    logic                 in_accept;
    logic                 out_accept;
    logic                 in_last;
    logic                 out_last;
    logic                 in_clear;
    logic                 timeout_hit;
    logic                 cap_fire;
    logic [CNT_W-1:0]     in_cnt;
    logic [CNT_W-1:0]     out_cnt;
    logic [BLOCK_W-1:0]   out_blk;
    logic [BLOCK_W-BYTE_W-1:0] out_rest_unused;

    // armed_q keeps In_ready low through the reset cycle.
    assign In_ready    = (state_q == ST_FILL) && armed_q;
    assign Out_valid   = (state_q == ST_DRAIN);
    assign Core_rst    = (state_q == ST_START);
    assign Busy        = (state_q != ST_FILL);
    assign Key_o       = key_q;
    assign Timeout_err = timeout_q;

    assign in_accept  = In_valid && In_ready;
    assign out_accept = Out_valid && Out_ready;
    assign in_last    = in_accept && (in_cnt == CNT_W'(NBYTES - 1));
    assign out_last   = out_accept && (out_cnt == CNT_W'(NBYTES - 1));
    assign in_clear   = timeout_hit || out_last;

    assign {Out_data, out_rest_unused} = out_blk;

    des128_byte_shifter u_in_sr (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (1'b0),
        .load_data ('0),
        .shift     (in_accept),
        .byte_in   (In_data),
        .clear     (in_clear),
        .data      (Plaintext_o),
        .cnt       (in_cnt)
    );

    des128_byte_shifter u_out_sr (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (cap_fire),
        .load_data (Cipher_i),
        .shift     (out_accept),
        .byte_in   ('0),
        .clear     (1'b0),
        .data      (out_blk),
        .cnt       (out_cnt)
    );

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        cap_fire    = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (in_last) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Done on the final timer cycle still counts as success.
                if (Core_done) begin
                    state_d = ST_WAITCAP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_FILL;
                end
            end
            ST_WAITCAP: begin
                if (timer_q == TMR_W'(CAP_DLY - 1)) begin
                    cap_fire = 1'b1;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_last) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_FILL;
            armed_q   <= 1'b0;
            timeout_q <= 1'b0;
            key_q     <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            if (Key_load && (state_q == ST_FILL)) begin
                key_q <= Key_in;
            end
        end
    end

    // One timer serves both the Done timeout and the capture delay; it restarts on every state change.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= '0;
        end else if (((state_q == ST_RUN) || (state_q == ST_WAITCAP)) &&
                     (timer_q != TMR_W'(TIMEOUT))) begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

endmodule

// File: tb/tb_des128_byte_loader.sv
// Randomized bench for des128_byte_loader: a behavioural DES-core stand-in plus a
// byte-queue scoreboard derived from the block/key the bench itself sent.
module tb_des128_byte_loader;

    localparam int TIMEOUT = 40;
    localparam int CAP_DLY = 1;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [127:0] Key_in;
    logic         Key_load;
    logic [7:0]   In_data;
    logic         In_valid;
    logic         In_ready;
    logic [127:0] Plaintext_o;
    logic [127:0] Key_o;
    logic         Core_rst;
    logic         Core_done;
    logic [127:0] Cipher_i;
    logic [7:0]   Out_data;
    logic         Out_valid;
    logic         Out_ready;
    logic         Busy;
    logic         Timeout_err;

    des128_byte_loader #(.TIMEOUT(TIMEOUT), .CAP_DLY(CAP_DLY)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Key_in      (Key_in),
        .Key_load    (Key_load),
        .In_data     (In_data),
        .In_valid    (In_valid),
        .In_ready    (In_ready),
        .Plaintext_o (Plaintext_o),
        .Key_o       (Key_o),
        .Core_rst    (Core_rst),
        .Core_done   (Core_done),
        .Cipher_i    (Cipher_i),
        .Out_data    (Out_data),
        .Out_valid   (Out_valid),
        .Out_ready   (Out_ready),
        .Busy        (Busy),
        .Timeout_err (Timeout_err)
    );

    always #5 Clk = ~Clk;

    int           n_checks   = 0;
    int           n_errors   = 0;
    int           cyc        = 0;
    int           core_delay = 0;
    int           done_cyc   = 0;
    int           rst_pulses = 0;
    int           ov_cycles  = 0;
    int           t_start    = 0;
    int           rdy_mode   = 0;
    logic [7:0]   exp_q[$];
    logic [127:0] exp_key    = '0;
    logic [7:0]   blk[16];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in for the DES transform: any fixed keyed mixing works for checking transport.
    function automatic logic [127:0] cipher_f(input logic [127:0] p, input logic [127:0] k);
        return ((p ^ k) + {p[63:0], p[127:64]}) ^ {k[7:0], k[127:8]};
    endfunction

    task automatic cycle_loop();
        forever begin
            @(posedge Clk);
            cyc++;
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                0:       Out_ready = 1'b1;
                1:       Out_ready = ~Out_ready;
                default: Out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    // Core model: restarts on Core_rst, pulses Done core_delay cycles later (0 = never).
    task automatic core_loop();
        int           cnt = 0;
        logic [127:0] pt_c = '0;
        logic [127:0] key_c = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                cnt       = 0;
                Core_done = 1'b0;
            end else begin
                Core_done = 1'b0;
                if (Core_rst) begin
                    pt_c     = Plaintext_o;
                    key_c    = Key_o;
                    cnt      = core_delay;
                    Cipher_i = rand128();
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        Core_done = 1'b1;
                        Cipher_i  = cipher_f(pt_c, key_c);
                        done_cyc  = cyc;
                        chk("pt_stable", Plaintext_o, pt_c);
                        chk("key_stable", Key_o, key_c);
                    end
                end
            end
        end
    endtask

    task automatic mon_loop();
        logic       prev_ov     = 1'b0;
        logic       prev_hold   = 1'b0;
        logic [7:0] prev_od     = '0;
        logic       expect_idle = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                prev_ov     = 1'b0;
                prev_hold   = 1'b0;
                expect_idle = 1'b0;
            end else begin
                if (Core_rst) rst_pulses++;
                if (expect_idle) begin
                    chk("busy_after_drain", 128'(Busy), 128'(0));
                    chk("ov_after_drain", 128'(Out_valid), 128'(0));
                    expect_idle = 1'b0;
                end
                if (prev_hold) begin
                    chk("ov_hold", 128'(Out_valid), 128'(1));
                    chk("od_hold", 128'(Out_data), 128'(prev_od));
                end
                if (Out_valid && !prev_ov) begin
                    chk("done_to_ov", 128'(cyc - done_cyc), 128'(CAP_DLY + 1));
                end
                if (Out_valid) ov_cycles++;
                if (Out_valid && Out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 128'(1), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_byte", 128'(Out_data), 128'(e));
                        if (exp_q.size() == 0) expect_idle = 1'b1;
                    end
                end
                prev_hold = Out_valid && !Out_ready;
                prev_od   = Out_data;
                prev_ov   = Out_valid;
            end
        end
    endtask

    task automatic watchdog();
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    endtask

    // Called and returns at posedge+1; holds In_valid until the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        In_valid = 1'b1;
        In_data  = b;
        @(negedge Clk);
        while (!In_ready && w < 100) begin
            @(negedge Clk);
            w++;
        end
        if (!In_ready) chk("in_ready_wait", 128'(In_ready), 128'(1));
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] k);
        Key_load = 1'b1;
        Key_in   = k;
        @(negedge Clk);
        chk("key_before_edge", Key_o, exp_key);
        @(posedge Clk);
        #1;
        Key_load = 1'b0;
        @(negedge Clk);
        chk("key_loaded", Key_o, k);
        exp_key = k;
        @(posedge Clk);
        #1;
    endtask

    task automatic run_block(input int delay, input bit gapped, input bit expect_out,
                             input bit key_in_run, input bit key_with_last);
        logic [127:0] pt;
        logic [127:0] c;
        int           w;
        int           snap;
        pt = '0;
        for (int i = 0; i < 16; i++) pt[127-8*i -: 8] = blk[i];
        core_delay = delay;
        snap       = rst_pulses;
        for (int i = 0; i < 16; i++) begin
            if (key_with_last && i == 15) begin
                Key_load = 1'b1;
                Key_in   = rand128();
                exp_key  = Key_in;
            end
            send_byte(blk[i]);
            Key_load = 1'b0;
            if (gapped && i < 15) begin
                @(negedge Clk);
                chk("in_ready_gap", 128'(In_ready), 128'(1));
                @(posedge Clk);
                #1;
            end
        end
        @(negedge Clk);
        t_start = cyc;
        chk("core_rst_start", 128'(Core_rst), 128'(1));
        chk("pt_at_start", Plaintext_o, pt);
        chk("key_at_start", Key_o, exp_key);
        chk("busy_start", 128'(Busy), 128'(1));
        chk("in_ready_start", 128'(In_ready), 128'(0));
        if (expect_out) begin
            c = cipher_f(pt, exp_key);
            for (int i = 0; i < 16; i++) exp_q.push_back(c[127-8*i -: 8]);
        end
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("core_rst_width", 128'(Core_rst), 128'(0));
        @(posedge Clk);
        #1;
        if (key_in_run) begin
            Key_load = 1'b1;
            Key_in   = ~exp_key;
            @(negedge Clk);
            @(posedge Clk);
            #1;
            Key_load = 1'b0;
            @(negedge Clk);
            chk("key_ignored_run", Key_o, exp_key);
            @(posedge Clk);
            #1;
        end
        if (expect_out) begin
            w = 0;
            do begin
                @(negedge Clk);
                w++;
            end while (Busy && w < 400);
            chk("drain_done", 128'(Busy), 128'(0));
            chk("sb_empty", 128'(exp_q.size()), 128'(0));
            chk("core_rst_pulses", 128'(rst_pulses - snap), 128'(1));
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic rand_blk();
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int w;
        int ov_snap;
        Reset     = 1'b0;
        Key_in    = '0;
        Key_load  = 1'b0;
        In_data   = '0;
        In_valid  = 1'b0;
        Core_done = 1'b0;
        Cipher_i  = '0;
        Out_ready = 1'b1;
        #1 Reset = 1'b1;
        fork
            cycle_loop();
            ready_loop();
            core_loop();
            mon_loop();
            watchdog();
        join_none

        // Reset values
        repeat (2) @(posedge Clk);
        #2;
        chk("rst_pt", Plaintext_o, 128'(0));
        chk("rst_key", Key_o, 128'(0));
        chk("rst_core_rst", 128'(Core_rst), 128'(0));
        chk("rst_in_ready", 128'(In_ready), 128'(0));
        chk("rst_out_valid", 128'(Out_valid), 128'(0));
        chk("rst_out_data", 128'(Out_data), 128'(0));
        chk("rst_busy", 128'(Busy), 128'(0));
        chk("rst_timeout", 128'(Timeout_err), 128'(0));
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("in_ready_after_reset", 128'(In_ready), 128'(1));
        @(posedge Clk);
        #1;

        // Known-answer style block: bytes 00..0F, no backpressure
        load_key(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        for (int i = 0; i < 16; i++) blk[i] = 8'(i);
        rdy_mode = 0;
        run_block(5, 1'b0, 1'b1, 1'b0, 1'b0);

        // Done after 18 cycles with Out_ready toggling
        rdy_mode = 1;
        rand_blk();
        run_block(18, 1'b0, 1'b1, 1'b0, 1'b0);

        // Gapped input, random backpressure
        rdy_mode = 2;
        rand_blk();
        run_block(int'($urandom_range(1, 30)), 1'b1, 1'b1, 1'b0, 1'b0);

        // Key_load during RUN ignored, then honoured in FILL
        rand_blk();
        run_block(18, 1'b0, 1'b1, 1'b1, 1'b0);
        load_key(rand128());

        // Key_load together with the 16th byte
        rand_blk();
        run_block(10, 1'b0, 1'b1, 1'b0, 1'b1);

        // Done on the last permitted RUN cycle
        rand_blk();
        run_block(TIMEOUT, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            rand_blk();
            run_block(int'($urandom_range(1, TIMEOUT)), 1'(r % 2), 1'b1, 1'b0, 1'b0);
        end

        // No Done at all: timeout after TIMEOUT cycles in RUN
        rand_blk();
        ov_snap = ov_cycles;
        run_block(0, 1'b0, 1'b0, 1'b0, 1'b0);
        w = 0;
        do begin
            @(negedge Clk);
            w++;
        end while (!Timeout_err && w < 200);
        chk("timeout_lat", 128'(cyc - t_start), 128'(TIMEOUT + 1));
        chk("timeout_busy", 128'(Busy), 128'(0));
        chk("timeout_in_ready", 128'(In_ready), 128'(1));
        chk("timeout_no_out", 128'(ov_cycles - ov_snap), 128'(0));
        @(posedge Clk);
        #1;

        // Done one cycle too late: still a timeout, late Done ignored in FILL
        rand_blk();
        ov_snap = ov_cycles;
        run_block(TIMEOUT + 1, 1'b0, 1'b0, 1'b0, 1'b0);
        w = 0;
        do begin
            @(negedge Clk);
            w++;
        end while (Busy && w < 200);
        chk("late_done_lat", 128'(cyc - t_start), 128'(TIMEOUT + 1));
        repeat (3) @(negedge Clk);
        chk("late_done_ignored", 128'(Busy), 128'(0));
        chk("late_done_no_out", 128'(ov_cycles - ov_snap), 128'(0));
        chk("timeout_sticky", 128'(Timeout_err), 128'(1));
        @(posedge Clk);
        #1;

        // Reset ten cycles into RUN
        rdy_mode = 2;
        rand_blk();
        run_block(18, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) @(posedge Clk);
        #1 Reset = 1'b1;
        #2;
        chk("mid_rst_pt", Plaintext_o, 128'(0));
        chk("mid_rst_key", Key_o, 128'(0));
        chk("mid_rst_core_rst", 128'(Core_rst), 128'(0));
        chk("mid_rst_in_ready", 128'(In_ready), 128'(0));
        chk("mid_rst_out_valid", 128'(Out_valid), 128'(0));
        chk("mid_rst_out_data", 128'(Out_data), 128'(0));
        chk("mid_rst_busy", 128'(Busy), 128'(0));
        chk("mid_rst_timeout", 128'(Timeout_err), 128'(0));
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        exp_key = '0;
        load_key(rand128());
        rand_blk();
        run_block(18, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
